// File: rtl/flash_sample_player.sv
// Streams 32-bit flash words as pairs of 16-bit samples (low half first), one word read at a time.
// Optional build macro LOOP_PLAYBACK_EN: wrap to the start address at end of range instead of stopping.
module flash_sample_player #(
    parameter int ADDR_W   = 23,
    parameter int SAMPLE_W = 16,
    parameter int DATA_W   = 2 * SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                play,
    input  logic                sample_tick,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic                mem_start,
    output logic                mem_inread,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_done,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                finished
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_MEM,
        OUT_LO,
        OUT_HI,
        ADVANCE,
        STOP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   start_q;
    logic [ADDR_W-1:0]   end_q;
    logic [DATA_W-1:0]   word;

    assign mem_inread = 1'b1;
    assign busy       = (state != IDLE);

    // NOTE: every register here is assigned with <= so all reads in this block see the
    // pre-edge values; a blocking = would let later branches observe half-updated state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            start_q      <= '0;
            end_q        <= '0;
            // NOTE: the word buffer is a single register, not a memory array, so it is
            // cheap to include in the reset and keeps sample_out deterministic.
            word         <= '0;
            mem_start    <= 1'b0;
            mem_addr     <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            finished     <= 1'b0;
        end else begin
            mem_start    <= 1'b0;
            sample_valid <= 1'b0;
            finished     <= 1'b0;

            case (state)
                IDLE: begin
                    if (play) begin
                        if (end_addr >= start_addr) begin
                            start_q   <= start_addr;
                            end_q     <= end_addr;
                            mem_addr  <= start_addr;
                            mem_start <= 1'b1;
                            state     <= REQ;
                        end else begin
                            finished <= 1'b1;
                            state    <= STOP;
                        end
                    end
                end

                REQ: begin
                    if (!play) begin
                        finished <= 1'b1;
                        state    <= STOP;
                    end else begin
                        state <= WAIT_MEM;
                    end
                end

                // A stop request is honoured only after the outstanding read returns.
                WAIT_MEM: begin
                    if (mem_done) begin
                        word  <= mem_data;
                        state <= OUT_LO;
                    end
                end

                OUT_LO: begin
                    if (!play) begin
                        finished <= 1'b1;
                        state    <= STOP;
                    end else if (sample_tick) begin
                        sample_out   <= word[SAMPLE_W-1:0];
                        sample_valid <= 1'b1;
                        state        <= OUT_HI;
                    end
                end

                OUT_HI: begin
                    if (!play) begin
                        finished <= 1'b1;
                        state    <= STOP;
                    end else if (sample_tick) begin
                        sample_out   <= word[DATA_W-1:SAMPLE_W];
                        sample_valid <= 1'b1;
                        state        <= ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (!play) begin
                        finished <= 1'b1;
                        state    <= STOP;
                    end else if (mem_addr == end_q) begin
`ifdef LOOP_PLAYBACK_EN
                        mem_addr  <= start_q;
                        mem_start <= 1'b1;
                        finished  <= 1'b1;
                        state     <= REQ;
`else
                        finished <= 1'b1;
                        state    <= STOP;
`endif
                    end else begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_start <= 1'b1;
                        state     <= REQ;
                    end
                end

                STOP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_player.sv
// Self-checking bench for flash_sample_player: flash controller responder, tick source,
// output monitors and a range-walk reference model.
module tb_flash_sample_player;

    localparam int ADDR_W   = 23;
    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                play = 1'b0;
    logic                sample_tick = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic [ADDR_W-1:0]   end_addr = '0;
    logic                mem_done = 1'b0;
    logic [DATA_W-1:0]   mem_data = '0;
    logic                mem_start;
    logic                mem_inread;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                busy;
    logic                finished;

    int compared = 0;
    int mismatched = 0;

    flash_sample_player #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .play(play), .sample_tick(sample_tick),
        .start_addr(start_addr), .end_addr(end_addr),
        .mem_start(mem_start), .mem_inread(mem_inread), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_data(mem_data),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .finished(finished)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0]   mem_model [int unsigned];
    logic [ADDR_W-1:0]   start_log [$];
    logic [SAMPLE_W-1:0] samp_log [$];
    int     fin_cnt, wrap_fin_cnt, proto_err;
    longint first_fin_time, done_time;
    bit     outstanding;
    int     tick_period = 20, tick_cnt = 0, fixed_lat = 0;
    bit     tick_en = 0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            if (mem_start === 1'b1) begin
                if (outstanding) proto_err++;
                outstanding = 1;
                start_log.push_back(mem_addr);
            end
            if (sample_valid === 1'b1) samp_log.push_back(sample_out);
            if (finished === 1'b1) begin
                fin_cnt++;
                if (first_fin_time < 0) first_fin_time = longint'($time);
                if (mem_start === 1'b1) wrap_fin_cnt++;
            end
        end
    end

    // Flash read controller model: done pulse 'latency' cycles after the request
    logic [ADDR_W-1:0] resp_addr;
    int                resp_lat;
    bit                resp_abort;
    always begin
        @(negedge clk);
        if (!reset && mem_start === 1'b1) begin
            resp_addr  = mem_addr;
            resp_lat   = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            resp_abort = 0;
            for (int i = 0; i < resp_lat; i++) begin
                @(negedge clk);
                if (reset) resp_abort = 1;
            end
            if (!resp_abort) begin
                mem_data    = mem_model.exists(int'(resp_addr)) ? mem_model[int'(resp_addr)] : 32'hDEAD_BEEF;
                mem_done    = 1'b1;
                done_time   = longint'($time);
                outstanding = 0;
                @(negedge clk);
                mem_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        tick_cnt++;
        if (tick_en && tick_cnt >= tick_period) begin
            sample_tick = 1'b1;
            tick_cnt    = 0;
        end else begin
            sample_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        start_log.delete();
        samp_log.delete();
        fin_cnt        = 0;
        wrap_fin_cnt   = 0;
        first_fin_time = -1;
        done_time      = -1;
    endtask

    // Play a range and stop as soon as finished pulses so IDLE does not re-arm
    task automatic run_range(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                             input int period, input string name);
        bit seen;
        start_addr  = s;
        end_addr    = e;
        tick_period = period;
        tick_cnt    = 0;
        tick_en     = 1;
        clear_log();
        seen = 0;
        play = 1'b1;
        for (int c = 0; c < 5000 && !seen; c++) begin
            @(negedge clk);
            if (finished === 1'b1) begin
                play = 1'b0;
                seen = 1;
            end
        end
        play    = 1'b0;
        tick_en = 0;
        repeat (4) @(negedge clk);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL %s timeout: finished got 0 want 1", name);
        end
    endtask

    // Reference: one read per word s..e, samples are low half then high half of each word
    task automatic check_against_model(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                                       input string name);
        logic [ADDR_W-1:0]   exp_start [$];
        logic [SAMPLE_W-1:0] exp_samp [$];
        logic [DATA_W-1:0]   w;
        int n;
        for (int unsigned x = s; x <= e; x++) begin
            w = mem_model[x];
            exp_start.push_back(ADDR_W'(x));
            exp_samp.push_back(w[15:0]);
            exp_samp.push_back(w[31:16]);
        end
        compared++;
        if (start_log.size() != exp_start.size()) begin
            mismatched++;
            $display("FAIL %s start_count: got %0d want %0d", name, start_log.size(), exp_start.size());
        end
        n = (start_log.size() < exp_start.size()) ? start_log.size() : exp_start.size();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (start_log[i] !== exp_start[i]) begin
                mismatched++;
                $display("FAIL %s start_addr[%0d]: got %h want %h", name, i, start_log[i], exp_start[i]);
            end
        end
        compared++;
        if (samp_log.size() != exp_samp.size()) begin
            mismatched++;
            $display("FAIL %s sample_count: got %0d want %0d", name, samp_log.size(), exp_samp.size());
        end
        n = (samp_log.size() < exp_samp.size()) ? samp_log.size() : exp_samp.size();
        for (int i = 0; i < n; i++) begin
            compared++;
            if (samp_log[i] !== exp_samp[i]) begin
                mismatched++;
                $display("FAIL %s sample[%0d]: got %h want %h", name, i, samp_log[i], exp_samp[i]);
            end
        end
        compared++;
        if (fin_cnt != 1) begin
            mismatched++;
            $display("FAIL %s finished_count: got %0d want 1", name, fin_cnt);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s busy_after: got %b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({mem_start, sample_valid, busy, finished} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b want 0000", {mem_start, sample_valid, busy, finished});
        end
        compared++;
        if (mem_addr !== '0) begin
            mismatched++;
            $display("FAIL reset_mem_addr: got %h want 0", mem_addr);
        end
        compared++;
        if (sample_out !== '0) begin
            mismatched++;
            $display("FAIL reset_sample_out: got %h want 0", sample_out);
        end
        compared++;
        if (mem_inread !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mem_inread: got %b want 1", mem_inread);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        mem_model[32'h10] = 32'hBBBB_AAAA;
        mem_model[32'h11] = 32'hDDDD_CCCC;
        run_range(23'h10, 23'h11, 20, "normal");
        check_against_model(23'h10, 23'h11, "normal");
    endtask

    task automatic test_single_word();
        mem_model[32'h7F_FFFF] = 32'h8000_7FFF;
        run_range(23'h7F_FFFF, 23'h7F_FFFF, 15, "single");
        check_against_model(23'h7F_FFFF, 23'h7F_FFFF, "single");
        compared++;
        if (mem_addr !== 23'h7F_FFFF) begin
            mismatched++;
            $display("FAIL single mem_addr_hold: got %h want 7fffff", mem_addr);
        end
    endtask

    task automatic test_invalid_range();
        bit seen = 0;
        start_addr = 23'h20;
        end_addr   = 23'h1F;
        clear_log();
        play = 1'b1;
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge clk);
            if (finished === 1'b1) begin
                play = 1'b0;
                seen = 1;
            end
        end
        play = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL invalid finished_within_2: got 0 want 1");
        end
        compared++;
        if (start_log.size() != 0) begin
            mismatched++;
            $display("FAIL invalid mem_start_count: got %0d want 0", start_log.size());
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL invalid busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_stop_during_fetch();
        bit got_start = 0, seen = 0;
        for (int unsigned a = 32'h40; a <= 32'h43; a++) mem_model[a] = $urandom;
        start_addr  = 23'h40;
        end_addr    = 23'h43;
        fixed_lat   = 5;
        tick_period = 3;
        tick_cnt    = 0;
        tick_en     = 1;
        clear_log();
        play = 1'b1;
        for (int c = 0; c < 20 && !got_start; c++) begin
            @(negedge clk);
            if (mem_start === 1'b1) got_start = 1;
        end
        @(negedge clk);
        play = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (finished === 1'b1) seen = 1;
        end
        tick_en = 0;
        repeat (3) @(negedge clk);
        fixed_lat = 0;
        compared++;
        if (!(got_start && seen)) begin
            mismatched++;
            $display("FAIL stopfetch timeout: start %0d finished %0d want 1 1", got_start, seen);
        end
        compared++;
        if (start_log.size() != 1) begin
            mismatched++;
            $display("FAIL stopfetch mem_start_count: got %0d want 1", start_log.size());
        end
        compared++;
        if (samp_log.size() != 0) begin
            mismatched++;
            $display("FAIL stopfetch sample_count: got %0d want 0", samp_log.size());
        end
        compared++;
        if (done_time < 0 || first_fin_time <= done_time) begin
            mismatched++;
            $display("FAIL stopfetch order: finished at %0d, done at %0d, want finished after done",
                     first_fin_time, done_time);
        end
        compared++;
        if (fin_cnt != 1) begin
            mismatched++;
            $display("FAIL stopfetch finished_count: got %0d want 1", fin_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        mem_model[32'h100] = 32'h1234_5678;
        mem_model[32'h101] = 32'h9ABC_DEF0;
        start_addr  = 23'h100;
        end_addr    = 23'h101;
        tick_period = 15;
        tick_cnt    = 0;
        tick_en     = 1;
        clear_log();
        play = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) seen = 1;
        end
        reset = 1'b1;
        #1;
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL resetmid timeout: sample_valid got 0 want 1");
        end
        compared++;
        if ({mem_start, sample_valid, busy, finished} !== 4'b0000) begin
            mismatched++;
            $display("FAIL resetmid strobes: got %b want 0000", {mem_start, sample_valid, busy, finished});
        end
        compared++;
        if (mem_addr !== '0 || sample_out !== '0) begin
            mismatched++;
            $display("FAIL resetmid regs: mem_addr %h sample_out %h want 0 0", mem_addr, sample_out);
        end
        play    = 1'b0;
        tick_en = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        compared++;
        if (start_log.size() != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL resetmid idle_after: mem_start %0d busy %b want 0 0", start_log.size(), busy);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] s, e;
        int len;
        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(1, 4));
            s   = (it == 0) ? 23'h7F_FFFC : ADDR_W'($urandom_range(0, 32'h7F_FFFB));
            e   = s + ADDR_W'(len - 1);
            for (int unsigned a = s; a <= e; a++) mem_model[a] = $urandom;
            run_range(s, e, int'($urandom_range(8, 30)), $sformatf("random%0d", it));
            check_against_model(s, e, $sformatf("random%0d", it));
        end
    endtask

`ifdef LOOP_PLAYBACK_EN
    task automatic test_loop();
        bit seen_v = 0, seen_f = 0;
        int zeros = 0;
        logic [DATA_W-1:0] w;
        mem_model[32'h0] = 32'h2222_1111;
        mem_model[32'h1] = 32'h4444_3333;
        start_addr  = 23'h0;
        end_addr    = 23'h1;
        tick_period = 10;
        tick_cnt    = 0;
        tick_en     = 1;
        clear_log();
        play = 1'b1;
        for (int c = 0; c < 2000 && start_log.size() < 6; c++) @(negedge clk);
        for (int c = 0; c < 100 && !seen_v; c++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) seen_v = 1;
        end
        play = 1'b0;
        for (int c = 0; c < 10 && !seen_f; c++) begin
            @(negedge clk);
            if (finished === 1'b1) seen_f = 1;
        end
        tick_en = 0;
        repeat (3) @(negedge clk);
        compared++;
        if (start_log.size() < 6 || !seen_f) begin
            mismatched++;
            $display("FAIL loop timeout: starts %0d stop %0d want >=6 1", start_log.size(), seen_f);
        end
        foreach (start_log[i]) begin
            if (start_log[i] == '0) zeros++;
            compared++;
            if (start_log[i] !== ADDR_W'(i % 2)) begin
                mismatched++;
                $display("FAIL loop start_addr[%0d]: got %h want %h", i, start_log[i], i % 2);
            end
        end
        foreach (samp_log[i]) begin
            w = mem_model[(i / 2) % 2];
            compared++;
            if (samp_log[i] !== ((i % 2 == 0) ? w[15:0] : w[31:16])) begin
                mismatched++;
                $display("FAIL loop sample[%0d]: got %h", i, samp_log[i]);
            end
        end
        compared++;
        if (wrap_fin_cnt != zeros - 1 || fin_cnt != zeros) begin
            mismatched++;
            $display("FAIL loop finished: wraps %0d total %0d want %0d %0d",
                     wrap_fin_cnt, fin_cnt, zeros - 1, zeros);
        end
    endtask
`endif

    initial begin
        proto_err = 0;
        clear_log();
        test_reset();
`ifndef LOOP_PLAYBACK_EN
        test_normal();
        test_single_word();
`endif
        test_invalid_range();
        test_stop_during_fetch();
        test_reset_mid();
`ifdef LOOP_PLAYBACK_EN
        test_loop();
`else
        test_random();
`endif
        compared++;
        if (proto_err != 0) begin
            mismatched++;
            $display("FAIL protocol: mem_start while read outstanding got %0d want 0", proto_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
